// File: rtl/neuron_act_pipe.sv
// Neuron output stage: saturating bias add, then a selectable activation.
// Two registered stages with valid/ready flow control and a saturation counter.
module neuron_act_pipe #(
  parameter int bitw  = 16,
  parameter int fracw = 8,
  parameter int cntw  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [bitw-1:0] in_data,
  input  logic [bitw-1:0] bias,
  input  logic [1:0]      act_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [bitw-1:0] out_data,
  output logic [cntw-1:0] sat_count,
  input  logic            clear_count
);

  localparam logic [bitw-1:0] MaxV =
    {1'b0, {(bitw-1){1'b1}}};
  localparam logic [bitw-1:0] MinV =
    {1'b1, {(bitw-1){1'b0}}};
  localparam logic [bitw-1:0] PosOne =
    bitw'(1) << fracw;
  localparam logic [bitw-1:0] NegOne =
    ~PosOne + bitw'(1);
  localparam logic [cntw-1:0] CntMax =
    {cntw{1'b1}};

  logic            s1_valid_q, s1_valid_d;
  logic [bitw-1:0] s1_data_q, s1_data_d;
  logic [1:0]      s1_act_q, s1_act_d;
  logic            out_valid_q, out_valid_d;
  logic [bitw-1:0] out_data_q, out_data_d;
  logic [cntw-1:0] cnt_q, cnt_d;

  logic            s2_load;
  logic            s1_adv;
  logic            in_fire;
  logic [bitw:0]   sum;
  logic            sat_hi;
  logic            sat_lo;
  logic            sat;
  logic [bitw-1:0] biased;
  logic [bitw-1:0] act_val;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_load;
  assign in_ready = !rst && (!s1_valid_q || s1_adv);
  assign in_fire  = in_valid && in_ready;

  // One extra bit of headroom exposes overflow in the top two bits.
  assign sum    = {in_data[bitw-1], in_data}
                + {bias[bitw-1], bias};
  assign sat_hi = !sum[bitw] && sum[bitw-1];
  assign sat_lo = sum[bitw] && !sum[bitw-1];
  assign sat    = sat_hi || sat_lo;

  always_comb begin
    biased = sum[bitw-1:0];
    if (sat_hi) biased = MaxV;
    if (sat_lo) biased = MinV;
  end

  always_comb begin
    act_val = s1_data_q;
    unique case (s1_act_q)
      2'd0: act_val = s1_data_q;
      2'd1: begin
        if (s1_data_q[bitw-1]) act_val = '0;
      end
      2'd2: begin
        if (s1_data_q[bitw-1])
          act_val = {{3{1'b1}}, s1_data_q[bitw-1:3]};
      end
      2'd3: begin
        if ($signed(s1_data_q) > $signed(PosOne))
          act_val = PosOne;
        else if ($signed(s1_data_q) < $signed(NegOne))
          act_val = NegOne;
      end
      default: act_val = s1_data_q;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_act_d   = s1_act_q;
    if (s1_adv) s1_valid_d = 1'b0;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = biased;
      s1_act_d   = act_sel;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_data_d = act_val;
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && sat && cnt_q != CntMax)
      cnt_d = cnt_q + cntw'(1);
    if (clear_count) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_act_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_act_q    <= s1_act_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_neuron_act_pipe.sv
// Bench for neuron_act_pipe: directed cases plus randomized traffic
// checked against an arithmetic reference model and scoreboard.
module tb_neuron_act_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] bias;
  logic [1:0]  act_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  sat_count;
  logic        clear_count;

  neuron_act_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias(bias), .act_sel(act_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_count(sat_count),
    .clear_count(clear_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [15:0] b;
    logic [1:0]  a;
  } beat_t;

  beat_t       pend[$];
  logic [15:0] expq[$];
  int          exp_cnt;
  int          checks;
  int          failures;
  int          rdy_mode;
  bit          vld_rand;
  int          clr_rate;
  int          nout;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(beat_t x,
                                        output bit sat);
    int dv, bv, s, v;
    dv = $signed(x.d);
    bv = $signed(x.b);
    s = dv + bv;
    sat = 0;
    if (s > 32767) begin s = 32767; sat = 1; end
    if (s < -32768) begin s = -32768; sat = 1; end
    v = s;
    case (x.a)
      2'd1: if (v < 0) v = 0;
      2'd2: if (v < 0) v = -((-v + 7) / 8);
      2'd3: begin
        if (v > 256) v = 256;
        if (v < -256) v = -256;
      end
      default: ;
    endcase
    return v[15:0];
  endfunction

  function automatic beat_t mk(logic [15:0] d,
                               logic [15:0] b,
                               logic [1:0] a);
    beat_t x;
    x.d = d; x.b = b; x.a = a;
    return x;
  endfunction

  // One clock: entered and left at a falling edge.
  task automatic cycle();
    bit fin, fout, stall, clr, sat;
    logic [15:0] pd;
    beat_t x;
    in_valid = pend.size() > 0 &&
               (!vld_rand || $urandom_range(0, 3) != 0);
    if (in_valid) begin
      in_data = pend[0].d;
      bias    = pend[0].b;
      act_sel = pend[0].a;
    end else begin
      in_data = 16'($urandom);
      bias    = 16'($urandom);
      act_sel = 2'($urandom);
    end
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = $urandom_range(0, 2) != 0;
    endcase
    clear_count = clr_rate > 0 &&
                  $urandom_range(1, clr_rate) == 1;
    #4;
    fin   = in_valid && in_ready;
    fout  = out_valid && out_ready;
    stall = out_valid && !out_ready;
    clr   = clear_count;
    pd    = out_data;
    @(posedge clk);
    #1;
    if (fout) begin
      nout++;
      if (expq.size() == 0) chk("spurious_out", 1, 0);
      else chk("out_data", pd, expq.pop_front());
    end
    if (stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, pd);
    end
    if (fin) begin
      x = pend.pop_front();
      expq.push_back(model(x, sat));
      if (sat && exp_cnt < 255) exp_cnt++;
    end
    if (clr) exp_cnt = 0;
    chk("sat_count", sat_count, exp_cnt);
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int k;
    k = 0;
    rdy_mode = 0;
    while ((pend.size() > 0 || expq.size() > 0) && k < 200) begin
      cycle();
      k++;
    end
    if (k >= 200) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    checks = 0; failures = 0; exp_cnt = 0;
    rdy_mode = 0; vld_rand = 0; clr_rate = 0; nout = 0;
    in_valid = 0; in_data = 0; bias = 0; act_sel = 0;
    out_ready = 1; clear_count = 0;
    rst = 1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat_count", sat_count, 0);
    rst = 0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    @(negedge clk);

    // Latency: present at cycle 0, out_valid after second edge.
    pend.push_back(mk(16'h0F00, 16'h0080, 2'd1));
    cycle();
    chk("lat_not_yet", out_valid, 0);
    cycle();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 16'h0F80);
    drain();

    pend.push_back(mk(16'h7F00, 16'h0200, 2'd0));
    pend.push_back(mk(16'h8100, 16'hFE00, 2'd0));
    pend.push_back(mk(16'hFD43, 16'h0000, 2'd1));
    pend.push_back(mk(16'hFD43, 16'h0000, 2'd2));
    pend.push_back(mk(16'hFD43, 16'h0000, 2'd0));
    pend.push_back(mk(16'h0300, 16'h0000, 2'd3));
    pend.push_back(mk(16'hFE00, 16'h0000, 2'd3));
    pend.push_back(mk(16'h0080, 16'h0000, 2'd3));
    drain();
    chk("sat_two", sat_count, 2);

    // Backpressure: only two beats can be held.
    pend.push_back(mk(16'h0100, 16'h0001, 2'd0));
    pend.push_back(mk(16'h0200, 16'h0002, 2'd0));
    pend.push_back(mk(16'h0300, 16'h0003, 2'd0));
    rdy_mode = 1;
    run(5);
    chk("bp_pending", pend.size(), 1);
    chk("bp_in_ready", in_ready, 0);
    rdy_mode = 0;
    nout = 0;
    run(3);
    chk("bp_b2b", nout, 3);
    drain();

    // Reset with two beats in flight and a count of three.
    pend.push_back(mk(16'h7FFF, 16'h7FFF, 2'd0));
    drain();
    chk("sat_three", sat_count, 3);
    pend.push_back(mk(16'h0010, 16'h0000, 2'd0));
    pend.push_back(mk(16'h0020, 16'h0000, 2'd0));
    rdy_mode = 1;
    run(3);
    chk("rst_pre_valid", out_valid, 1);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_count", sat_count, 0);
    chk("mid_rst_ready", in_ready, 0);
    pend.delete();
    expq.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 0;
    pend.push_back(mk(16'h0040, 16'h0004, 2'd1));
    rdy_mode = 0;
    cycle();
    cycle();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 16'h0044);
    drain();

    // Random traffic, including extremes and clears.
    rdy_mode = 2; vld_rand = 1; clr_rate = 25;
    for (int i = 0; i < 600; i++) begin
      if (pend.size() < 3) begin
        logic [15:0] d, b;
        d = 16'($urandom);
        b = 16'($urandom);
        if ($urandom_range(0, 3) == 0) d = {d[15], 15'h7F00};
        pend.push_back(mk(d, b, 2'($urandom)));
      end
      cycle();
    end
    vld_rand = 0; clr_rate = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
